// File: rtl/step_dir_generator_pkg.sv
// Shared definitions for the step/dir generator: FSM state encoding and the
// default timing parameters used when an instance does not override them.
package step_dir_generator_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDirSetup  = 2'd1,
    StPulseHigh = 2'd2,
    StPulseLow  = 2'd3
  } state_e;

  localparam int unsigned DefPulseWidth = 16;  // step high time in clk cycles
  localparam int unsigned DefDirSetup   = 8;   // dir change to next step rise, clk cycles

endpackage

// File: rtl/step_dir_generator_if.sv
// Move-command channel of the step/dir generator.
//   cmd_valid/cmd_ready : handshake, transfer when both are high on a clk edge
//   cmd_dir             : 1 = forward (+), 0 = reverse (-)
//   cmd_steps           : number of step pulses to emit (0 is legal)
//   cmd_period          : requested spacing of step rising edges in clk cycles
//   abort               : stop the current move after the pulse in progress
// master = command source, slave = generator.
interface step_dir_generator_if #(
  parameter int unsigned move_bits   = 32,
  parameter int unsigned period_bits = 24
) ();
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_dir;
  logic [move_bits-1:0]   cmd_steps;
  logic [period_bits-1:0] cmd_period;
  logic                   abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    output cmd_ready
  );
endinterface

// File: rtl/step_dir_generator_cycle_timer.sv
// Loadable down-counter shared by every timed phase of the generator.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : load load_value this cycle (takes priority over counting)
//   load_value  : phase length minus one
//   expired     : count has reached zero; a phase loaded with N-1 lasts N cycles
module step_dir_generator_cycle_timer #(
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             expired
);
  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - One;
    end
  end

  assign expired = (count_q == '0);
endmodule

// File: rtl/step_dir_generator.sv
// Step/dir initiator: turns move commands into timed step pulses and a dir level
// for a dual H-bridge, and tracks a signed position mirroring the bridge count.
//   clk, resetn     : clock, asynchronous active-low reset
//   cmd             : command channel (slave side), see step_dir_generator_if
//   step, dir       : registered outputs to the bridge
//   busy            : move in progress
//   done            : one-cycle pulse at move completion or abort
//   steps_remaining : pulses still to emit in the current move
//   position        : signed running position, wraps in two's complement
module step_dir_generator
  import step_dir_generator_pkg::*;
#(
  parameter int unsigned move_bits     = 32,
  parameter int unsigned period_bits   = 24,
  parameter int unsigned position_bits = 32,
  parameter int unsigned pulse_width   = DefPulseWidth,
  parameter int unsigned dir_setup     = DefDirSetup
) (
  input  logic                            clk,
  input  logic                            resetn,
  step_dir_generator_if.slave             cmd,
  output logic                            step,
  output logic                            dir,
  output logic                            busy,
  output logic                            done,
  output logic [move_bits-1:0]            steps_remaining,
  output logic signed [position_bits-1:0] position
);
  // One extra bit so 2*pulse_width and the clamp compare never overflow.
  localparam int unsigned ExtBits = period_bits + 1;
  localparam logic [ExtBits-1:0]     MinPeriod = ExtBits'(2 * pulse_width);
  localparam logic [ExtBits-1:0]     PwExt     = ExtBits'(pulse_width);
  localparam logic [ExtBits-1:0]     ExtOne    = ExtBits'(1);
  localparam logic [period_bits-1:0] HighLoad  = period_bits'(pulse_width - 1);
  localparam logic [period_bits-1:0] SetupLoad = period_bits'(dir_setup - 1);
  localparam logic [move_bits-1:0]   StepOne   = move_bits'(1);
  localparam logic signed [position_bits-1:0] PosOne = position_bits'(1);

  state_e             state_q;
  logic               ready_q;   // holds cmd_ready low until the first cycle after reset
  logic               abort_q;
  logic [ExtBits-1:0] period_q;  // effective period of the current move

  logic                     abort_any, accept, cmd_zero;
  logic                     start_setup, start_high, start_low, move_end, setup_abort;
  logic [ExtBits-1:0]       cmd_period_ext, eff_period;
  logic [period_bits-1:0]   low_load, timer_value;
  logic                     timer_load, expired;
  logic signed [position_bits-1:0] pos_stepped;

  always_comb begin
    abort_any      = abort_q | cmd.abort;
    accept         = (state_q == StIdle) & ready_q & cmd.cmd_valid;
    cmd_zero       = (cmd.cmd_steps == '0);
    cmd_period_ext = {1'b0, cmd.cmd_period};
    eff_period     = (cmd_period_ext > MinPeriod) ? cmd_period_ext : MinPeriod;
    start_setup    = accept & ~cmd_zero & (cmd.cmd_dir != dir);
    setup_abort    = (state_q == StDirSetup) & abort_any;
    move_end       = (state_q == StPulseLow) & expired &
                     ((steps_remaining == '0) | abort_any);
    start_high     = (accept & ~cmd_zero & (cmd.cmd_dir == dir)) |
                     ((state_q == StDirSetup) & expired & ~abort_any) |
                     ((state_q == StPulseLow) & expired & ~move_end);
    start_low      = (state_q == StPulseHigh) & expired;
    // After an abort the trailing low phase is only pulse_width long.
    low_load       = abort_any ? HighLoad : period_bits'(period_q - PwExt - ExtOne);
    timer_load     = start_setup | start_high | start_low;
    timer_value    = '0;
    if (start_setup) begin
      timer_value = SetupLoad;
    end else if (start_high) begin
      timer_value = HighLoad;
    end else if (start_low) begin
      timer_value = low_load;
    end
    pos_stepped    = dir ? position + PosOne : position - PosOne;
  end

  step_dir_generator_cycle_timer #(
    .Width(period_bits)
  ) u_cycle_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (timer_load),
    .load_value(timer_value),
    .expired   (expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      ready_q         <= 1'b0;
      abort_q         <= 1'b0;
      period_q        <= '0;
      step            <= 1'b0;
      dir             <= 1'b0;
      done            <= 1'b0;
      steps_remaining <= '0;
      position        <= '0;
    end else begin
      ready_q <= 1'b1;
      done    <= 1'b0;
      if ((state_q != StIdle) && cmd.abort) begin
        abort_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            steps_remaining <= cmd.cmd_steps;
            period_q        <= eff_period;
            if (cmd_zero) begin
              done <= 1'b1;
            end else if (start_setup) begin
              dir     <= cmd.cmd_dir;
              state_q <= StDirSetup;
            end else begin
              state_q         <= StPulseHigh;
              step            <= 1'b1;
              position        <= pos_stepped;
              steps_remaining <= cmd.cmd_steps - StepOne;
            end
          end
        end
        StDirSetup: begin
          if (setup_abort) begin
            state_q <= StIdle;
            done    <= 1'b1;
            abort_q <= 1'b0;
          end else if (start_high) begin
            state_q         <= StPulseHigh;
            step            <= 1'b1;
            position        <= pos_stepped;
            steps_remaining <= steps_remaining - StepOne;
          end
        end
        StPulseHigh: begin
          if (start_low) begin
            state_q <= StPulseLow;
            step    <= 1'b0;
          end
        end
        StPulseLow: begin
          if (move_end) begin
            state_q <= StIdle;
            done    <= 1'b1;
            abort_q <= 1'b0;
          end else if (start_high) begin
            state_q         <= StPulseHigh;
            step            <= 1'b1;
            position        <= pos_stepped;
            steps_remaining <= steps_remaining - StepOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q & (state_q == StIdle);
  assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_step_dir_generator.sv
module tb_step_dir_generator;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  step_dir_generator_if #(.move_bits(32), .period_bits(24)) cmd_if ();
  step_dir_generator_if #(.move_bits(32), .period_bits(24)) cmd2_if ();

  logic        step1, dir1, busy1, done1;
  logic [31:0] sr1, pos1;
  logic        step2, dir2, busy2, done2;
  logic [31:0] sr2;
  logic [7:0]  pos2;

  step_dir_generator #(
    .move_bits(32), .period_bits(24), .position_bits(32), .pulse_width(16), .dir_setup(8)
  ) u_dut (
    .clk(clk), .resetn(resetn), .cmd(cmd_if), .step(step1), .dir(dir1), .busy(busy1),
    .done(done1), .steps_remaining(sr1), .position(pos1)
  );

  step_dir_generator #(
    .move_bits(32), .period_bits(24), .position_bits(8), .pulse_width(16), .dir_setup(8)
  ) u_dut_wrap (
    .clk(clk), .resetn(resetn), .cmd(cmd2_if), .step(step2), .dir(dir2), .busy(busy2),
    .done(done2), .steps_remaining(sr2), .position(pos2)
  );

  // Timeline monitor for u_dut and a bridge step counter for u_dut_wrap.
  int       rise_q[$];
  int       high_q[$];
  int       done_q[$];
  int       high_cnt   = 0;
  logic     step_prev  = 1'b0;
  int       rise2      = 0;
  logic [7:0] model2   = 8'd0;
  logic     step2_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (step1 && !step_prev) rise_q.push_back(cyc);
    if (step1) high_cnt++;
    else if (step_prev) begin
      high_q.push_back(high_cnt);
      high_cnt = 0;
    end
    if (done1) done_q.push_back(cyc);
    step_prev = step1;
    if (step2 && !step2_prev) begin
      rise2++;
      model2 = dir2 ? model2 + 8'd1 : model2 - 8'd1;
    end
    step2_prev = step2;
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.abort      = 1'b0;
    cmd2_if.cmd_valid = 1'b0;
    cmd2_if.abort     = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rise_q.delete();
    high_q.delete();
    done_q.delete();
    high_cnt = 0; step_prev = 1'b0;
    rise2 = 0; model2 = 8'd0; step2_prev = 1'b0;
  endtask

  // Offer a command on u_dut; t is the cycle number of the accepting edge.
  task automatic issue(input logic d, input logic [31:0] s, input logic [23:0] p,
                       output int t);
    int n = 0;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_steps  = s;
    cmd_if.cmd_period = p;
    while (cmd_if.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: cmd_ready=%b after %0d cycles, required 1",
               cmd_if.cmd_ready, n);
    end
    @(posedge clk);
    #1;
    t = cyc;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int want, input int budget);
    int n = 0;
    while (done_q.size() < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_q.size() < want) begin
      failures++;
      $display("FAIL done_timeout: done pulses=%0d, required %0d within %0d cycles",
               done_q.size(), want, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({step1, dir1, busy1, done1, cmd_if.cmd_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: step,dir,busy,done,ready=%b required 00000",
               {step1, dir1, busy1, done1, cmd_if.cmd_ready});
    end
    checks++;
    if (sr1 !== 32'd0 || pos1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts: steps_remaining=%0d position=%0d required 0 0", sr1, pos1);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_same_dir();
    int t;
    do_reset();
    issue(1'b0, 32'd3, 24'd40, t);
    checks++;
    if (busy1 !== 1'b1 || sr1 !== 32'd2 || pos1 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL same_first_edge: busy=%b sr=%0d pos=%0d required 1 2 -1",
               busy1, sr1, $signed(pos1));
    end
    wait_done(1, 400);
    checks++;
    if (rise_q.size() != 3 || rise_q[0] != t || rise_q[1] != t + 40 || rise_q[2] != t + 80) begin
      failures++;
      $display("FAIL same_rises: n=%0d at %0d %0d %0d, required 3 at %0d %0d %0d",
               rise_q.size(), rise_q[0], rise_q[1], rise_q[2], t, t + 40, t + 80);
    end
    checks++;
    if (high_q.size() != 3 || high_q[0] != 16 || high_q[1] != 16 || high_q[2] != 16) begin
      failures++;
      $display("FAIL same_width: n=%0d widths %0d %0d %0d, required 3 x 16",
               high_q.size(), high_q[0], high_q[1], high_q[2]);
    end
    checks++;
    if (done_q[0] != t + 120) begin
      failures++;
      $display("FAIL same_done_time: got %0d required %0d", done_q[0], t + 120);
    end
    checks++;
    if (pos1 !== 32'hFFFF_FFFD || sr1 !== 32'd0 || dir1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL same_final: pos=%0d sr=%0d dir=%b busy=%b required -3 0 0 0",
               $signed(pos1), sr1, dir1, busy1);
    end
  endtask

  task automatic test_dir_change();
    int t;
    do_reset();
    issue(1'b1, 32'd2, 24'd100, t);
    checks++;
    if (dir1 !== 1'b1 || step1 !== 1'b0) begin
      failures++;
      $display("FAIL dirchg_setup: dir=%b step=%b required 1 0", dir1, step1);
    end
    wait_done(1, 400);
    checks++;
    if (rise_q.size() != 2 || rise_q[0] != t + 8 || rise_q[1] != t + 108) begin
      failures++;
      $display("FAIL dirchg_rises: n=%0d at %0d %0d, required 2 at %0d %0d",
               rise_q.size(), rise_q[0], rise_q[1], t + 8, t + 108);
    end
    checks++;
    if (done_q[0] != t + 208 || pos1 !== 32'd2) begin
      failures++;
      $display("FAIL dirchg_final: done at %0d pos=%0d, required %0d 2",
               done_q[0], $signed(pos1), t + 208);
    end
  endtask

  task automatic test_clamp_zero();
    int t;
    int t2;
    do_reset();
    issue(1'b0, 32'd2, 24'd5, t);
    wait_done(1, 200);
    checks++;
    if (rise_q.size() != 2 || rise_q[0] != t || rise_q[1] != t + 32 || done_q[0] != t + 64) begin
      failures++;
      $display("FAIL clamp_timing: n=%0d rises %0d %0d done %0d, required 2 %0d %0d %0d",
               rise_q.size(), rise_q[0], rise_q[1], done_q[0], t, t + 32, t + 64);
    end
    checks++;
    if (high_q[0] != 16 || high_q[1] != 16 || pos1 !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL clamp_width_pos: widths %0d %0d pos=%0d required 16 16 -2",
               high_q[0], high_q[1], $signed(pos1));
    end
    rise_q.delete();
    done_q.delete();
    issue(1'b1, 32'd0, 24'd40, t2);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || dir1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_accept: done=%b busy=%b dir=%b required 1 0 0", done1, busy1, dir1);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rise_q.size() != 0 || done_q.size() != 1 || done_q[0] != t2 || pos1 !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL zero_after: rises=%0d dones=%0d at %0d pos=%0d, required 0 1 %0d -2",
               rise_q.size(), done_q.size(), done_q[0], $signed(pos1), t2);
    end
  endtask

  task automatic test_abort_back_to_back();
    int t;
    int t2;
    do_reset();
    issue(1'b0, 32'd10, 24'd64, t);
    while (cyc < t + 195) @(negedge clk);
    // Abort inside pulse 4 high; queue the next command behind it.
    cmd_if.abort      = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = 1'b1;
    cmd_if.cmd_steps  = 32'd1;
    cmd_if.cmd_period = 24'd40;
    @(negedge clk);
    cmd_if.abort = 1'b0;
    wait_done(1, 100);
    checks++;
    if (done1 !== 1'b1 || cmd_if.cmd_ready !== 1'b1 || done_q[0] != t + 224) begin
      failures++;
      $display("FAIL abort_done: done=%b ready=%b at %0d, required 1 1 %0d",
               done1, cmd_if.cmd_ready, done_q[0], t + 224);
    end
    checks++;
    if (rise_q.size() != 4 || high_q.size() != 4 || high_q[3] != 16) begin
      failures++;
      $display("FAIL abort_pulses: rises=%0d falls=%0d last width=%0d, required 4 4 16",
               rise_q.size(), high_q.size(), high_q[3]);
    end
    checks++;
    if (sr1 !== 32'd6 || pos1 !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL abort_residual: sr=%0d pos=%0d required 6 -4", sr1, $signed(pos1));
    end
    @(posedge clk);
    #1;
    t2 = cyc;
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || dir1 !== 1'b1 || sr1 !== 32'd1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b dir=%b sr=%0d required 1 1 1", busy1, dir1, sr1);
    end
    wait_done(2, 200);
    checks++;
    if (rise_q.size() != 5 || rise_q[4] != t2 + 8 || done_q[1] != t2 + 48 ||
        pos1 !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL b2b_move: rises=%0d last %0d done %0d pos=%0d, required 5 %0d %0d -3",
               rise_q.size(), rise_q[4], done_q[1], $signed(pos1), t2 + 8, t2 + 48);
    end
  endtask

  task automatic test_abort_setup();
    int t;
    do_reset();
    issue(1'b1, 32'hFFFF_FFFF, 24'd40, t);
    @(negedge clk);
    @(negedge clk);
    cmd_if.abort = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || step1 !== 1'b0 || dir1 !== 1'b1) begin
      failures++;
      $display("FAIL setup_abort: done=%b busy=%b step=%b dir=%b required 1 0 0 1",
               done1, busy1, step1, dir1);
    end
    @(negedge clk);
    cmd_if.abort = 1'b0;
    checks++;
    if (sr1 !== 32'hFFFF_FFFF || pos1 !== 32'd0 || rise_q.size() != 0) begin
      failures++;
      $display("FAIL setup_residual: sr=%h pos=%0d rises=%0d required ffffffff 0 0",
               sr1, $signed(pos1), rise_q.size());
    end
  endtask

  task automatic test_reset_mid_move();
    int t;
    int n = 0;
    do_reset();
    issue(1'b0, 32'd5, 24'd40, t);
    while (step1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (step1 !== 1'b0 || busy1 !== 1'b0 || pos1 !== 32'd0 || cmd_if.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: step=%b busy=%b pos=%0d ready=%b required 0 0 0 0",
               step1, busy1, $signed(pos1), cmd_if.cmd_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || busy1 !== 1'b0 || step1 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release: ready=%b busy=%b step=%b required 1 0 0",
               cmd_if.cmd_ready, busy1, step1);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    @(negedge clk);
    cmd2_if.cmd_valid  = 1'b1;
    cmd2_if.cmd_dir    = 1'b1;
    cmd2_if.cmd_steps  = 32'd130;
    cmd2_if.cmd_period = 24'd0;
    @(posedge clk);
    #1;
    cmd2_if.cmd_valid = 1'b0;
    while (done2 !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done2 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_timeout: done=%b after %0d cycles, required 1", done2, n);
    end
    checks++;
    if (pos2 !== 8'h82 || rise2 != 130) begin
      failures++;
      $display("FAIL wrap_position: pos=%0d rises=%0d required -126 130",
               $signed(pos2), rise2);
    end
    checks++;
    if (model2 !== pos2 || busy2 !== 1'b0 || sr2 !== 32'd0 || dir2 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_bridge: model=%0d pos=%0d busy=%b sr=%0d dir=%b required equal 0 0 1",
               $signed(model2), $signed(pos2), busy2, sr2, dir2);
    end
  endtask

  initial begin
    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_dir     = 1'b0;
    cmd_if.cmd_steps   = 32'd0;
    cmd_if.cmd_period  = 24'd0;
    cmd_if.abort       = 1'b0;
    cmd2_if.cmd_valid  = 1'b0;
    cmd2_if.cmd_dir    = 1'b0;
    cmd2_if.cmd_steps  = 32'd0;
    cmd2_if.cmd_period = 24'd0;
    cmd2_if.abort      = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_same_dir();
    test_dir_change();
    test_clamp_zero();
    test_abort_back_to_back();
    test_abort_setup();
    test_reset_mid_move();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
